// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - state_t and the IDLE/RUN/DONE state constants
//   - DEFAULT_WIDTH, the default operand width
//   - cnt_width(), the bit width of the iteration counter (ceil(log2(width)))
// -----------------------------------------------------------------------------
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

  // ceil(log2(w)), never less than 1 so the counter always has a bit.
  function automatic int cnt_width(input int w);
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << n) < w) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_mult_unit_add_stage.sv
// -----------------------------------------------------------------------------
// mult_add_stage
// Purely combinational PW-bit conditional adder used for one partial-product
// accumulation step.
// Ports:
//   acc_i    PW  current accumulator
//   addend_i PW  shifted multiplicand
//   en_i     1   current multiplier LSB; add only when set
//   sum_o    PW  next accumulator value (carry out is dropped; it cannot occur
//                because the full product always fits in PW bits)
// -----------------------------------------------------------------------------
module mult_add_stage #(
  parameter int PW = 8
) (
  input  logic [PW-1:0] acc_i,
  input  logic [PW-1:0] addend_i,
  input  logic          en_i,
  output logic [PW-1:0] sum_o
);

  always_comb begin
    sum_o = acc_i;
    if (en_i) sum_o = acc_i + addend_i;
  end

endmodule

// File: rtl/seq_mult_unit.sv
// -----------------------------------------------------------------------------
// seq_mult_unit
// Sequential shift-and-add unsigned multiplier, one multiply at a time.
// A start is accepted in IDLE or DONE; the unit then spends WIDTH cycles in
// RUN (one partial product per cycle), pulses done for one cycle and holds p
// until the next result is produced.
//
// Handshake: start is sampled on every rising edge and accepted only when
// busy is low (state IDLE or DONE); a and b are captured on that same edge.
// start while busy is ignored. done is high for exactly one cycle, and p is
// valid in that cycle and stays valid until the next done.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request a multiply
//   a      in   WIDTH    multiplicand
//   b      in   WIDTH    multiplier
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, p valid
//   p      out  2*WIDTH  product
//
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN
//   When defined, RUN also exits as soon as the shifted multiplier becomes
//   zero, so latency is max(1, highest set bit index of b + 1) cycles.
//
// The FSM state is held in state_q for external checkers.
// -----------------------------------------------------------------------------
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;

  logic [PW-1:0]   acc_sum;
  logic [WIDTH-1:0] mplr_shift;
  logic            run_last;

  mult_add_stage #(.PW(PW)) u_add (
    .acc_i    (acc_q),
    .addend_i (mcand_q),
    .en_i     (mplr_q[0]),
    .sum_o    (acc_sum)
  );

  assign mplr_shift = mplr_q >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // No remaining multiplier bits means no further partial products to add.
  assign run_last = (cnt_q == CNT_LAST) || (mplr_shift == '0);
`else
  assign run_last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, a};
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + CW'(1);
        if (run_last) begin
          // Publish the final sum on the exit edge so p lines up with done.
          p_d     = acc_sum;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_unit
// Self-checking bench for seq_mult_unit (WIDTH=4). The driver pushes the
// expected product, latency and accept cycle into queues; an independent
// monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_seq_mult_unit;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  seq_mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            lat_q[$];
  int            accept_q[$];
  int            n_total = 0;
  int            n_pass  = 0;
  logic [PW-1:0] last_p  = '0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: ordinary multiplication, latency from the bit length of b.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] aa, input logic [W-1:0] bb);
    int unsigned r;
    r = int'(aa) * int'(bb);
    return PW'(r);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] bb);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int bits;
    bits = 0;
    for (int v = int'(bb); v != 0; v = v / 2) bits++;
    return (bits < 1) ? 1 : bits;
`else
    return W;
`endif
  endfunction

  // ---------------- monitor ----------------
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          logic [PW-1:0] e;
          int l, ac;
          e  = exp_q.pop_front();
          l  = lat_q.pop_front();
          ac = accept_q.pop_front();
          check("product", p, e);
          check("latency", cyc - ac, l);
          check("busy_cycles", busy_cnt, l);
          last_p = e;
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_not_busy_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Issue one start pulse at a negedge; optionally record an expectation.
  task automatic do_mult(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit expect_it);
    wait_not_busy();
    start = 1'b1;
    a = aa;
    b = bb;
    if (expect_it) begin
      exp_q.push_back(ref_prod(aa, bb));
      lat_q.push_back(ref_lat(bb));
      accept_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l;
    // reset state
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_p", p, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_mult(4'h3, 4'h5, 1'b1);
    wait_drain();
    do_mult(4'hF, 4'hF, 1'b1);
    wait_drain();
    do_mult(4'h0, 4'h9, 1'b1);
    wait_drain();
    do_mult(4'h4, 4'h4, 1'b1);
    do_mult(4'h5, 4'h0, 1'b1);
    do_mult(4'h7, 4'h1, 1'b1);
    wait_drain();

    // busy guard: second start during RUN must be ignored
    do_mult(4'h2, 4'h3, 1'b1);
    start = 1'b1;
    a = 4'hF;
    b = 4'hF;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);
    check("busy_guard_p_held", p, 8'h06);

    // back-to-back: start held through DONE
    l = ref_lat(4'h2);
    wait_not_busy();
    start = 1'b1;
    a = 4'h6;
    b = 4'h2;
    exp_q.push_back(8'h0C);
    lat_q.push_back(l);
    accept_q.push_back(cyc + 1);
    exp_q.push_back(8'h0C);
    lat_q.push_back(l);
    accept_q.push_back(cyc + 1 + l + 1);
    repeat (l + 2) @(negedge clk);
    start = 1'b0;
    check("b2b_done_gap", done, 0);
    check("b2b_relaunch_busy", busy, 1);
    wait_drain();

    // randomized operands with random gaps, some starts issued from DONE
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      do_mult(ra, rb, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    // p held in IDLE until the next start
    repeat (3) @(negedge clk);
    check("p_held_idle", p, last_p);

    // reset mid-operation: abort, no done afterwards
    do_mult(4'h7, 4'h7, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_p", p, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
